// File: rtl/rf_wb_scheduler.sv
// Round-robin writeback arbiter for the single register-file write port,
// with a busy scoreboard of registers that still have a write outstanding.
module rf_wb_scheduler #(
    parameter int NREQ    = 3,
    parameter int NREGS   = 13,
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 we,
    output logic [AW-1:0]        waddr,
    output logic [DW-1:0]        wbdata,
    input  logic                 alloc_valid,
    input  logic [AW-1:0]        alloc_addr,
    input  logic                 flush,
    output logic [NREGS-1:0]     busy,
    output logic                 addr_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] NR = (AW+1)'(NREGS);

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    nxt_ptr;
    logic             found;
    logic             xfer;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic             sel_in_range;
    logic             sel_is_r0;
    logic             wr_ok;
    logic             bad_req;
    logic             alloc_in_range;
    logic             alloc_ok;
    logic             bad_alloc;
    logic [NREGS-1:0] busy_nxt;

    // Search order starts at rr_ptr and wraps; first valid requester wins.
    always_comb begin
        req_ready = '0;
        found     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] &&
                    i == ((int'(rr_ptr) + k) % NREQ)) begin
                    found        = 1'b1;
                    req_ready[i] = 1'b1;
                end
            end
        end
        if (flush) req_ready = '0;
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        nxt_ptr  = rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
                nxt_ptr  = PW'((i + 1) % NREQ);
            end
        end
    end

    assign xfer         = |req_ready;
    assign sel_in_range = {1'b0, sel_addr} < NR;
    assign sel_is_r0    = ZERO_R0 && (sel_addr == '0);
    assign wr_ok        = xfer && !flush && sel_in_range && !sel_is_r0;
    assign bad_req      = xfer && !sel_in_range;

    assign alloc_in_range = {1'b0, alloc_addr} < NR;
    assign alloc_ok  = alloc_valid && !flush && alloc_in_range &&
                       !(ZERO_R0 && alloc_addr == '0);
    assign bad_alloc = alloc_valid && !flush && !alloc_in_range;

    // Clear on write first, then set on alloc so a new producer wins.
    always_comb begin
        busy_nxt = busy;
        for (int r = 0; r < NREGS; r++) begin
            if (we && waddr == AW'(r)) busy_nxt[r] = 1'b0;
        end
        for (int r = 0; r < NREGS; r++) begin
            if (alloc_ok && alloc_addr == AW'(r)) busy_nxt[r] = 1'b1;
        end
        if (flush) busy_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wbdata   <= '0;
            busy     <= '0;
            addr_err <= 1'b0;
        end else begin
            if (xfer) rr_ptr <= nxt_ptr;
            we <= wr_ok;
            if (wr_ok) begin
                waddr  <= sel_addr;
                wbdata <= sel_data;
            end
            addr_err <= addr_err | bad_req | bad_alloc;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: arbitration order, registered write,
// scoreboard priority, address filtering and flush.
module tb_rf_wb_scheduler;

    localparam int NREQ  = 3;
    localparam int NREGS = 13;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [DW-1:0]        wbdata;
    logic                 alloc_valid;
    logic [AW-1:0]        alloc_addr;
    logic                 flush;
    logic [NREGS-1:0]     busy;
    logic                 addr_err;

    int n_chk;
    int n_fail;

    rf_wb_scheduler #(
        .NREQ(NREQ), .NREGS(NREGS), .AW(AW), .DW(DW), .ZERO_R0(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .we(we), .waddr(waddr), .wbdata(wbdata),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .flush(flush), .busy(busy), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        reset       = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
        flush       = 1'b0;
        step();
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wbdata", wbdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err", addr_err, 0);
        check("rst_ready", req_ready, 0);
        step();
        reset = 1'b0;
        step();

        // 1: reset before the accepting edge discards the request
        set_req(0, 1'b1, 5'd5, 32'hA5A5A5A5);
        #1;
        check("t1_ready", req_ready, 3'b001);
        reset = 1'b1;
        #1;
        set_req(0, 1'b0, 5'd0, 32'h0);
        step();
        reset = 1'b0;
        check("t1_we_in_rst", we, 0);
        step();
        check("t1_we_after", we, 0);
        check("t1_busy", busy, 0);
        // accepted write visible, then async reset kills it at once
        set_req(0, 1'b1, 5'd5, 32'hA5A5A5A5);
        step();
        set_req(0, 1'b0, 5'd0, 32'h0);
        check("t1_we_wr", we, 1);
        reset = 1'b1;
        #1;
        check("t1_we_async", we, 0);
        check("t1_waddr_async", waddr, 0);
        step();
        reset = 1'b0;
        step();

        // 2: round-robin with all three valid
        set_req(0, 1'b1, 5'd1, 32'h100);
        set_req(1, 1'b1, 5'd2, 32'h200);
        set_req(2, 1'b1, 5'd3, 32'h300);
        #1;
        for (int k = 0; k < 6; k++) begin
            automatic int g = k % 3;
            check($sformatf("t2_grant%0d", k), req_ready, 3'b001 << g);
            step();
            check($sformatf("t2_we%0d", k), we, 1);
            check($sformatf("t2_waddr%0d", k), waddr, g + 1);
            check($sformatf("t2_data%0d", k), wbdata, (g + 1) * 32'h100);
        end
        req_valid = '0;
        step();
        check("t2_we_idle", we, 0);
        check("t2_waddr_hold", waddr, 3);
        check("t2_data_hold", wbdata, 32'h300);

        // 3: scoreboard set by alloc, cleared by the write
        alloc_valid = 1'b1;
        alloc_addr  = 5'd7;
        step();
        alloc_valid = 1'b0;
        check("t3_busy_set", busy, 13'h080);
        set_req(1, 1'b1, 5'd7, 32'h77);
        #1;
        check("t3_grant1", req_ready, 3'b010);
        step();
        req_valid = '0;
        check("t3_we", we, 1);
        check("t3_waddr", waddr, 7);
        check("t3_busy_still", busy, 13'h080);
        step();
        check("t3_busy_clr", busy, 0);
        check("t3_we_off", we, 0);

        // 4: set and clear of the same register in one cycle
        alloc_valid = 1'b1;
        alloc_addr  = 5'd7;
        step();
        alloc_valid = 1'b0;
        set_req(2, 1'b1, 5'd7, 32'h99);
        #1;
        check("t4_grant2", req_ready, 3'b100);
        step();
        req_valid   = '0;
        check("t4_we", we, 1);
        alloc_valid = 1'b1;
        alloc_addr  = 5'd7;
        step();
        alloc_valid = 1'b0;
        check("t4_busy_wins", busy, 13'h080);

        // 5: filtering of r0 and out-of-range addresses
        set_req(0, 1'b1, 5'd0, 32'h1234);
        #1;
        check("t5_grant0", req_ready, 3'b001);
        step();
        req_valid = '0;
        check("t5_we_r0", we, 0);
        check("t5_err_r0", addr_err, 0);
        alloc_valid = 1'b1;
        alloc_addr  = 5'd0;
        step();
        alloc_valid = 1'b0;
        check("t5_busy0", busy, 13'h080);
        set_req(1, 1'b1, 5'd13, 32'h5555);
        #1;
        check("t5_grant1", req_ready, 3'b010);
        step();
        req_valid = '0;
        check("t5_we_oor", we, 0);
        check("t5_err_set", addr_err, 1);
        step();
        check("t5_err_sticky", addr_err, 1);

        // 6: flush clears scoreboard, blocks grants, keeps pointer at 2
        alloc_valid = 1'b1;
        alloc_addr  = 5'd2;
        step();
        alloc_addr  = 5'd8;
        step();
        alloc_valid = 1'b0;
        check("t6_busy_pre", busy, 13'h184);
        set_req(0, 1'b1, 5'd4, 32'h44);
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd3;
        #1;
        check("t6_ready_flush", req_ready, 0);
        step();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        check("t6_busy_clr", busy, 0);
        check("t6_we", we, 0);
        check("t6_err_kept", addr_err, 1);
        set_req(1, 1'b1, 5'd5, 32'h55);
        set_req(2, 1'b1, 5'd6, 32'h66);
        #1;
        check("t6_ptr_kept", req_ready, 3'b100);
        step();
        req_valid = '0;
        check("t6_waddr", waddr, 6);
        check("t6_data", wbdata, 32'h66);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
